reg_rr_arbiter: RTL and testbench
=================================

REG_RR_ARBITER -- requirements
Module: reg_rr_arbiter

Interface
REQ-001 Parameter NoPorts, default 2, number of reg_pkg::reg_req_t requesters sharing one register port.
REQ-002 Parameter TimeoutCycles, default 255, BUSY cycles without out_rsp_i.ready before an error response; 0 disables the timeout.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 in_req_i  input  reg_req_t[NoPorts]  requester ports; index 0 is the external CSR port, index 1 the safe-CPU wrapper port.
REQ-006 in_rsp_o  output  reg_rsp_t[NoPorts]  per-requester responses.
REQ-007 out_req_o  output  reg_req_t  request to the wrapper CSR block.
REQ-008 out_rsp_i  input  reg_rsp_t  response from the wrapper CSR block.
REQ-009 timeout_o  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-010 FSM states: IDLE, BUSY; reset state IDLE.
REQ-011 IDLE: out_req_o.valid=0; all in_rsp_o ready/error/rdata=0.
REQ-012 IDLE with >=1 in_req_i[k].valid: next edge latch sel = first valid index searched round-robin from (last_grant+1) mod NoPorts; go BUSY; counter cleared.
REQ-013 IDLE with no valid request: stay IDLE; last_grant unchanged.
REQ-014 BUSY: out_req_o = in_req_i[sel] combinationally (addr, write, wdata, wstrb, valid); grant-to-output latency is exactly 1 cycle after valid is first seen.
REQ-015 BUSY: in_rsp_o[sel] = out_rsp_i combinationally; every non-selected in_rsp_o is all-zero.
REQ-016 BUSY with out_rsp_i.ready=1: transaction completes that cycle; next edge last_grant=sel, go IDLE.
REQ-017 Back-to-back: a requester may not be regranted before passing through one IDLE cycle; minimum transaction is 2 cycles.
REQ-018 Counter width $clog2(TimeoutCycles+1); increments each BUSY cycle without ready; saturates, never wraps.
REQ-019 Counter == TimeoutCycles (TimeoutCycles>0) and out_rsp_i.ready=0: that cycle in_rsp_o[sel].ready=1, error=1, rdata=0, out_req_o.valid=0, timeout_o=1; next edge go IDLE, last_grant=sel.
REQ-020 Simultaneous ready and timeout in the same cycle: ready wins, downstream response forwarded, timeout_o=0.
REQ-021 in_req_i[sel].valid dropping in BUSY (protocol violation): out_req_o.valid follows it to 0; next edge go IDLE, no response, last_grant=sel.
REQ-022 Requests from non-selected ports are held pending, never dropped or acknowledged, until granted.
REQ-023 Fairness: with all ports continuously valid, each port granted once per NoPorts transactions.

Reset
REQ-024 rst_ni low: state=IDLE, sel=0, last_grant=NoPorts-1 (port 0 wins first), counter=0, all outputs 0, regardless of an in-flight transaction.
REQ-025 Reset release: first grant possible at the first rising edge with rst_ni high.

Structure
REQ-026 Default TimeoutCycles constant CSR_ARB_TIMEOUT and the NoPorts value for the system live in cei_mochila_pkg; reg_req_t/reg_rsp_t come from reg_pkg.
REQ-027 One sub-module, reg_rr_arb_pick: combinational round-robin selector (valid vector, last_grant -> sel, any_valid).
REQ-028 Block replaces reg_mux between the periph_to_reg output and wrapper_csr_req_o without port-type changes.

Verification
REQ-029 Single request: port 0 write addr 0x10 data 0xDEADBEEF, ready after 3 cycles -> out_req_o valid 1 cycle after request, in_rsp_o[0].ready on 4th BUSY cycle, port 1 sees zeros.
REQ-030 Contention: both ports valid from reset, ready on every BUSY cycle -> grant order 0,1,0,1; each transaction 2 cycles.
REQ-031 Timeout: TimeoutCycles=4, downstream never ready -> in_rsp_o[sel].error=1, ready=1, timeout_o pulse on 5th BUSY cycle (counter==4), then IDLE.
REQ-032 Ready coincident with timeout cycle -> rdata 0x1234 forwarded, error=0, timeout_o=0.
REQ-033 rst_ni asserted mid-BUSY -> all outputs 0 asynchronously; after release port 0 granted first.
REQ-034 Requester drops valid in BUSY -> out_req_o.valid=0 same cycle, IDLE next cycle, no ready issued.

Source files
------------

// File: rtl/cei_mochila_pkg.sv
// cei_mochila_pkg: system-level constants and shared types for the CSR arbiter
package cei_mochila_pkg;
  localparam int unsigned CSR_ARB_NPORTS  = 2;
  localparam int unsigned CSR_ARB_TIMEOUT = 255;
  typedef enum logic {IDLE, BUSY} arb_state_e;
endpackage

// File: rtl/reg_pkg.sv
// reg_pkg: register-bus request/response types shared by requesters and CSR blocks
package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

// File: rtl/reg_rr_arb_pick.sv
// reg_rr_arb_pick: combinational round-robin selector starting after last_grant_i
module reg_rr_arb_pick #(
  parameter  int unsigned NoPorts = 2,
  localparam int unsigned IdxW    = NoPorts > 1 ? $clog2(NoPorts) : 1
) (
  input  logic [NoPorts-1:0] valid_i,
  input  logic [IdxW-1:0]    last_grant_i,
  output logic [IdxW-1:0]    sel_o,
  output logic               any_valid_o
);
  logic [IdxW-1:0] idx;
  // Walk from farthest to nearest so the closest valid port after last_grant wins.
  always_comb begin
    sel_o       = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    for (int i = NoPorts; i >= 1; i--) begin
      idx = IdxW'((int'(last_grant_i) + i) % NoPorts);
      if (valid_i[idx]) begin
        sel_o       = idx;
        any_valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter: round-robin arbiter sharing one register port among NoPorts requesters,
// with an optional BUSY timeout that answers the stalled requester with an error.
module reg_rr_arbiter
  import reg_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NoPorts       = CSR_ARB_NPORTS,
  parameter int unsigned TimeoutCycles = CSR_ARB_TIMEOUT
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t in_req_i [NoPorts],
  output reg_rsp_t in_rsp_o [NoPorts],
  output reg_req_t out_req_o,
  input  reg_rsp_t out_rsp_i,
  output logic     timeout_o
);
  localparam int unsigned IdxW   = NoPorts > 1 ? $clog2(NoPorts) : 1;
  localparam int unsigned CntW   = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  localparam reg_rsp_t    TmoRsp = '{rdata: '0, error: 1'b1, ready: 1'b1};
  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    sel_q, sel_d, last_q, last_d, pick_sel;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NoPorts-1:0] valid;
  logic               any_valid, req_v, tmo;
  always_comb begin
    valid = '0;
    for (int k = 0; k < NoPorts; k++) valid[k] = in_req_i[k].valid;
  end
  reg_rr_arb_pick #(.NoPorts(NoPorts)) u_pick (
    .valid_i      (valid),
    .last_grant_i (last_q),
    .sel_o        (pick_sel),
    .any_valid_o  (any_valid)
  );
  // A dropped requester valid aborts silently; ready from downstream beats the timeout.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    out_req_o = '0;
    timeout_o = 1'b0;
    for (int k = 0; k < NoPorts; k++) in_rsp_o[k] = '0;
    req_v = in_req_i[sel_q].valid;
    tmo   = (TimeoutCycles != 0) && cnt_q == CntW'(TimeoutCycles) && req_v && !out_rsp_i.ready;
    if (state_q == IDLE) begin
      if (any_valid) begin
        state_d = BUSY;
        sel_d   = pick_sel;
        cnt_d   = '0;
      end
    end else begin
      out_req_o       = in_req_i[sel_q];
      out_req_o.valid = req_v && !tmo;
      timeout_o       = tmo;
      if (req_v) in_rsp_o[sel_q] = tmo ? TmoRsp : out_rsp_i;
      if (!req_v || out_rsp_i.ready || tmo) begin
        state_d = IDLE;
        last_d  = sel_q;
      end else begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= IdxW'(NoPorts - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_reg_rr_arbiter.sv
// tb_reg_rr_arbiter: directed table-driven bench for the round-robin register arbiter
module tb_reg_rr_arbiter;
  import reg_pkg::*;
  localparam int unsigned N = 2;
  localparam int unsigned T = 4;
  localparam reg_rsp_t Z = '0;
  typedef struct {
    logic        v0, v1, rdy;
    logic [31:0] rdata;
    int          op;
    logic        ov;
    reg_rsp_t    rs0, rs1;
    logic        to;
  } vec_t;
  logic     clk_i = 1'b0;
  logic     rst_ni = 1'b0;
  reg_req_t in_req_i [N];
  reg_rsp_t in_rsp_o [N];
  reg_req_t out_req_o;
  reg_rsp_t out_rsp_i;
  logic     timeout_o;
  int       tests = 0;
  int       fails = 0;
  vec_t     vecs[$];
  reg_rr_arbiter #(.NoPorts(N), .TimeoutCycles(T)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_req_i  (in_req_i),
    .in_rsp_o  (in_rsp_o),
    .out_req_o (out_req_o),
    .out_rsp_i (out_rsp_i),
    .timeout_o (timeout_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic reg_req_t preq(int p, logic v);
    return p == 0 ? '{addr: 32'h10, write: 1'b1, wdata: 32'hDEADBEEF, wstrb: 4'hF, valid: v}
                  : '{addr: 32'h20, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: v};
  endfunction
  function automatic reg_rsp_t rsp(logic [31:0] rd, logic e, logic r);
    return '{rdata: rd, error: e, ready: r};
  endfunction
  function automatic vec_t mk(logic v0, logic v1, logic rdy, logic [31:0] rd, int op, logic ov,
                              reg_rsp_t s0, reg_rsp_t s1, logic to);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.rdata = rd; v.op = op; v.ov = ov;
    v.rs0 = s0; v.rs1 = s1; v.to = to;
    return v;
  endfunction
  task automatic drive(logic v0, logic v1, logic rdy, logic [31:0] rd);
    in_req_i[0] = preq(0, v0);
    in_req_i[1] = preq(1, v1);
    out_rsp_i   = rsp(rd, 1'b0, rdy);
  endtask
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(string tag, reg_req_t oreq, reg_rsp_t s0, reg_rsp_t s1, logic to);
    chk({tag, " out_req"}, 128'(out_req_o), 128'(oreq));
    chk({tag, " rsp0"}, 128'(in_rsp_o[0]), 128'(s0));
    chk({tag, " rsp1"}, 128'(in_rsp_o[1]), 128'(s1));
    chk({tag, " timeout"}, 128'(timeout_o), 128'(to));
  endtask
  initial begin
    // single transaction: port 0, downstream ready on the 4th BUSY cycle
    vecs.push_back(mk(0,0,0,0,          0,0,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          0,0,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,1,32'hCAFE,   1,1,rsp(32'hCAFE,0,1),Z,0));
    vecs.push_back(mk(0,0,0,0,          0,0,Z,Z,0));
    // contention after port 0 was last: grants go 1,0,1
    vecs.push_back(mk(1,1,1,32'h11,     0,0,Z,Z,0));
    vecs.push_back(mk(1,1,1,32'h11,     2,1,Z,rsp(32'h11,0,1),0));
    vecs.push_back(mk(1,1,1,32'h11,     0,0,Z,Z,0));
    vecs.push_back(mk(1,1,1,32'h11,     1,1,rsp(32'h11,0,1),Z,0));
    vecs.push_back(mk(1,1,1,32'h11,     0,0,Z,Z,0));
    vecs.push_back(mk(1,1,1,32'h11,     2,1,Z,rsp(32'h11,0,1),0));
    // timeout on the 5th BUSY cycle
    vecs.push_back(mk(1,0,0,0,          0,0,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,32'h5555,   1,0,rsp(0,1,1),Z,1));
    // ready coincident with the timeout cycle
    vecs.push_back(mk(1,0,0,0,          0,0,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,0,0,          1,1,Z,Z,0));
    vecs.push_back(mk(1,0,1,32'h1234,   1,1,rsp(32'h1234,0,1),Z,0));
    // requester 1 drops valid mid-BUSY: no response, back to IDLE
    vecs.push_back(mk(0,1,0,0,          0,0,Z,Z,0));
    vecs.push_back(mk(0,1,0,0,          2,1,Z,Z,0));
    vecs.push_back(mk(0,0,1,32'h77,     2,0,Z,Z,0));
    vecs.push_back(mk(0,0,0,0,          0,0,Z,Z,0));
    drive(0, 0, 0, 0);
    #1;
    chk_all("in_reset", '0, Z, Z, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].v0, vecs[i].v1, vecs[i].rdy, vecs[i].rdata);
      #2;
      chk_all($sformatf("row%0d", i), vecs[i].op == 0 ? '0 : preq(vecs[i].op - 1, vecs[i].ov),
              vecs[i].rs0, vecs[i].rs1, vecs[i].to);
    end
    // asynchronous reset in the middle of a port-1 transaction
    @(negedge clk_i);
    drive(0, 1, 0, 0);
    #2;
    chk_all("pre_rst_idle", '0, Z, Z, 0);
    @(negedge clk_i);
    #2;
    chk_all("pre_rst_busy", preq(1, 1), Z, Z, 0);
    drive(1, 1, 1, 32'hABCD);
    rst_ni = 1'b0;
    #1;
    chk_all("mid_rst", '0, Z, Z, 0);
    @(negedge clk_i);
    chk_all("held_rst", '0, Z, Z, 0);
    rst_ni = 1'b1;
    #2;
    chk_all("rst_release", '0, Z, Z, 0);
    // both ports continuously valid from reset: port 0 first, then strict alternation
    for (int t = 0; t < 4; t++) begin
      @(negedge clk_i);
      #2;
      chk_all($sformatf("fair%0d_busy", t), preq(t % 2, 1),
              t % 2 == 0 ? rsp(32'hABCD, 0, 1) : Z, t % 2 == 1 ? rsp(32'hABCD, 0, 1) : Z, 0);
      @(negedge clk_i);
      #2;
      chk_all($sformatf("fair%0d_idle", t), '0, Z, Z, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
